dmem_responder: RTL and testbench

- Word-organised data-memory responder: the target end of the CPU data port (data_read/data_write/data_addr/data_in -> data_out).
- Sits outside the CPU in the top-level and testbench. Serves loads with a registered 1-cycle latency and commits stores on the clock edge.
- Flags misaligned, out-of-range and conflicting accesses.
- An optional post-reset clear sequencer zero-fills the array before the block accepts traffic.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encoding and sizing helpers for the data-memory responder
package dmem_responder_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int WORD_BYTES = 4;

    // Width of a word index; never below one bit so a 1-word array still has an address.
    function automatic int index_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM, synchronous write, registered read
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          rclr,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive rst; only the clear sequencer in the parent zero-fills them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else if (rclr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: decode, clear sequencer, error flags and access counters
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          CLEAR_ON_RESET = 1,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_read,
    input  logic             data_write,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             addr_err,
    output logic             proto_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int          IW    = index_width(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

    logic [31:0]   off;
    logic          legal;
    logic [IW-1:0] index;

    state_t        state, state_next;
    logic [IW-1:0] ptr, ptr_next;

    logic          ready;
    logic          arr_we, arr_re, arr_rclr;
    logic [IW-1:0] arr_addr;
    logic [31:0]   arr_wdata;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
    assign off   = data_addr - BASE_ADDR;
    assign legal = (data_addr[1:0] == 2'b00) && ({1'b0, off} < LIMIT);
    assign index = off[IW+1:2];

    assign ready = (state == ST_READY);
    assign busy  = (state == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_rclr   = 1'b0;
        arr_addr   = index;
        arr_wdata  = data_in;
        case (state)
            ST_CLEAR: begin
                arr_we    = 1'b1;
                arr_addr  = ptr;
                arr_wdata = '0;
                ptr_next  = ptr + 1'b1;
                if (ptr == IW'(DEPTH_WORDS - 1)) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                // A simultaneous read is dropped; the store still goes ahead.
                arr_we   = data_write && legal;
                arr_re   = data_read && !data_write && legal;
                arr_rclr = data_read && !data_write && !legal;
            end
            default: state_next = ST_READY;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IW         (IW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .re   (arr_re),
        .rclr (arr_rclr),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(data_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
            proto_err  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            data_valid <= ready && data_read && !data_write;
            addr_err   <= ready && (data_read || data_write) && !legal;
            if (ready && data_read && data_write) begin
                proto_err <= 1'b1;
            end
            if (arr_re && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
            if (ready && arr_we && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_read = 1'b0;
    logic          data_write = 1'b0;
    logic [31:0]   data_addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          data_valid;
    logic          busy;
    logic          addr_err;
    logic          proto_err;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_out;
    logic        exp_valid, exp_err, exp_proto;
    int          exp_rd, exp_wr, clear_left;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .CLEAR_ON_RESET(1),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_read (data_read),
        .data_write(data_write),
        .data_addr (data_addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .addr_err  (addr_err),
        .proto_err (proto_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"}, data_out, exp_out);
        check({tag, ".data_valid"}, 32'(data_valid), 32'(exp_valid));
        check({tag, ".addr_err"}, 32'(addr_err), 32'(exp_err));
        check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_proto));
        check({tag, ".rd_count"}, 32'(rd_count), 32'(exp_rd));
        check({tag, ".wr_count"}, 32'(wr_count), 32'(exp_wr));
    endtask

    task automatic do_reset();
        data_read  = 1'b0;
        data_write = 1'b0;
        rst        = 1'b1;
        #2;
        exp_out    = '0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_proto  = 1'b0;
        exp_rd     = 0;
        exp_wr     = 0;
        clear_left = DEPTH;
        // After the clear sequence completes every word reads as zero.
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        check_outputs("reset");
        check("reset.busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One request cycle: drive, take the edge, update the model, compare.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic        legal;
        int          idx;
        data_read  = rd;
        data_write = wr;
        data_addr  = a;
        data_in    = d;
        check({tag, ".busy"}, 32'(busy), 32'(clear_left > 0));
        @(posedge clk);
        #1;
        off   = a - BASE;
        legal = ((a % 4) == 0) && (off < DEPTH * 4);
        idx   = int'(off / 4);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            exp_err = (rd || wr) && !legal;
            if (rd && wr) exp_proto = 1'b1;
            if (wr) begin
                if (legal) begin
                    mem_m[idx] = d;
                    if (exp_wr < CMAX) exp_wr++;
                end
            end else if (rd) begin
                exp_valid = 1'b1;
                if (legal) begin
                    exp_out = mem_m[idx];
                    if (exp_rd < CMAX) exp_rd++;
                end else begin
                    exp_out = '0;
                end
            end
        end
        check_outputs(tag);
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic random_step(input string tag);
        logic [31:0] a;
        logic        rd, wr;
        int          kind;
        case ($urandom_range(0, 9))
            0:       a = ({28'(0), 4'($urandom_range(0, 15))} << 2) | 32'($urandom_range(1, 3));
            1:       a = $urandom;
            2:       a = BASE + DEPTH * 4 + ({28'(0), 4'($urandom_range(0, 15))} << 2);
            default: a = BASE + ({28'(0), 4'($urandom_range(0, DEPTH - 1))} << 2);
        endcase
        kind = $urandom_range(0, 9);
        rd = (kind <= 3) || (kind == 7);
        wr = (kind >= 4) && (kind <= 7);
        step(tag, rd, wr, a, $urandom);
    endtask

    initial begin
        do_reset();
        // Requests during the clear sequence must be ignored.
        for (int i = 0; i < DEPTH; i++) random_step("clear_busy");
        step("clear_rd3c", 1'b1, 1'b0, 32'h3C, '0);

        step("raw_wr", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
        step("raw_rd", 1'b1, 1'b0, 32'h8, '0);
        check("raw_value", data_out, 32'hDEADBEEF);

        step("misaligned_rd", 1'b1, 1'b0, 32'h6, '0);
        step("oor_wr", 1'b0, 1'b1, 32'h40, 32'h12345678);
        step("alias_rd0", 1'b1, 1'b0, 32'h0, '0);

        step("conflict", 1'b1, 1'b1, 32'h4, 32'hA5A5A5A5);
        step("conflict_rd", 1'b1, 1'b0, 32'h4, '0);
        step("idle", 1'b0, 1'b0, 32'h4, '0);

        for (int i = 0; i < 17; i++) step("sat_rd", 1'b1, 1'b0, 32'h8, '0);
        check("sat_rd_count", 32'(rd_count), 32'(CMAX));

        do_reset();
        for (int i = 0; i < 5; i++) random_step("midclear_a");
        do_reset();
        for (int i = 0; i < DEPTH; i++) random_step("midclear_b");
        step("midclear_done", 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 400; i++) random_step("rand");

        do_reset();
        for (int i = 0; i < 200; i++) random_step("rand2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
